// File: rtl/gfx_instruction_queue.sv
// Circular instruction queue between the CPU store path and the graphics engine.
// Latency: a capture is readable from the next edge; C_INS updates on the edge that detects an advance.
// Backpressure: none; captures while full are dropped and latched in the sticky OVERFLOW flag.
module gfx_instruction_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              HF_CLK,
  input  logic              RST,
  input  logic              BLANK,
  input  logic [DATA_W-1:0] INS,
  input  logic              INS_EN,
  input  logic              DEDUP_EN,
  input  logic              LOOP,
  input  logic              CHANGE_C_INS,
  output logic [DATA_W-1:0] C_INS,
  output logic              C_VALID,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVERFLOW
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_PTR = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Instruction storage; deliberately not cleared by reset or blanking.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] rpl_idx_q, rpl_idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] last_ins_q, last_ins_d;
  logic              last_valid_q, last_valid_d;
  logic              chg_d_q, chg_d_d;
  logic              loop_q, loop_d;
  logic [DATA_W-1:0] c_ins_q, c_ins_d;
  logic              c_valid_q, c_valid_d;
  logic              overflow_q, overflow_d;

  logic              clr;
  logic              cap;
  logic              wr_ok;
  logic              adv;
  logic              rd_ok;
  logic              fifo_rd;
  logic              loop_rd;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rpl_inc;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W:0]   count_dec;

  // Event decode: capture, edge-detected advance and the replay address.
  always_comb begin
    clr       = RST | BLANK;
    cap       = INS_EN & (~DEDUP_EN | ~last_valid_q | (INS != last_ins_q));
    // Write admission uses the pre-edge FULL so a same-edge read cannot make room.
    wr_ok     = cap & ~full_q;
    adv       = CHANGE_C_INS & ~chg_d_q;
    rd_ok     = adv & ~empty_q;
    fifo_rd   = rd_ok & ~LOOP;
    loop_rd   = rd_ok & LOOP;
    rd_addr   = LOOP ? (rd_ptr_q + rpl_idx_q) : rd_ptr_q;
    rpl_inc   = rpl_idx_q + ONE_PTR;
    count_inc = {{ADDR_W{1'b0}}, wr_ok};
    count_dec = {{ADDR_W{1'b0}}, fifo_rd};
  end

  // Next-state computation for all control and output registers.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rpl_idx_d    = rpl_idx_q;
    count_d      = count_q;
    last_ins_d   = last_ins_q;
    last_valid_d = last_valid_q;
    chg_d_d      = CHANGE_C_INS;
    loop_d       = LOOP;
    c_ins_d      = c_ins_q;
    c_valid_d    = c_valid_q;
    overflow_d   = overflow_q;

    if (cap) begin
      last_ins_d   = INS;
      last_valid_d = 1'b1;
      if (full_q) begin
        overflow_d = 1'b1;
      end
    end
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end

    if (adv) begin
      if (rd_ok) begin
        c_ins_d   = mem[rd_addr];
        c_valid_d = 1'b1;
      end else begin
        c_valid_d = 1'b0;
      end
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end
    if (loop_rd) begin
      // Replay index wraps at the current occupancy, not at the memory depth.
      rpl_idx_d = (({1'b0, rpl_idx_q} + ONE_CNT) == count_q) ? '0 : rpl_inc;
    end
    // A mode change restarts replay from the oldest stored entry.
    if (LOOP != loop_q) begin
      rpl_idx_d = '0;
    end

    count_d = count_q + count_inc - count_dec;
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);

    if (clr) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      rpl_idx_d    = '0;
      count_d      = '0;
      full_d       = 1'b0;
      empty_d      = 1'b1;
      last_ins_d   = '0;
      last_valid_d = 1'b0;
      chg_d_d      = 1'b0;
      loop_d       = 1'b0;
      c_ins_d      = '0;
      c_valid_d    = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  // Memory write port; suppressed on clearing edges.
  always_ff @(posedge HF_CLK) begin
    if (!clr && wr_ok) begin
      mem[wr_ptr_q] <= INS;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge HF_CLK) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rpl_idx_q    <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      last_ins_q   <= '0;
      last_valid_q <= 1'b0;
      chg_d_q      <= 1'b0;
      loop_q       <= 1'b0;
      c_ins_q      <= '0;
      c_valid_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rpl_idx_q    <= rpl_idx_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      last_ins_q   <= last_ins_d;
      last_valid_q <= last_valid_d;
      chg_d_q      <= chg_d_d;
      loop_q       <= loop_d;
      c_ins_q      <= c_ins_d;
      c_valid_q    <= c_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign C_INS    = c_ins_q;
  assign C_VALID  = c_valid_q;
  assign COUNT    = count_q;
  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign OVERFLOW = overflow_q;

endmodule
